// File: rtl/jtag_bscan_tap.sv
// jtag_bscan_tap: IEEE 1149.1 TAP controller with boundary-scan, IDCODE and bypass data registers
// Ports: TCK clock; TRST async active-high reset; TMS/TDI sampled on TCK rise;
//        TDO/TDO_EN registered on TCK fall; pin_in/core_in input boundary cells;
//        core_out/pin_out output boundary cells; tap_state = standard 1149.1 state code.
module jtag_bscan_tap #(
   parameter int          IR_W       = 4,
   parameter int          BSR_IN_W   = 5,
   parameter int          BSR_OUT_W  = 4,
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
   input  logic                 TCK,
   input  logic                 TRST,
   input  logic                 TMS,
   input  logic                 TDI,
   output logic                 TDO,
   output logic                 TDO_EN,
   input  logic [BSR_IN_W-1:0]  pin_in,
   output logic [BSR_IN_W-1:0]  core_in,
   input  logic [BSR_OUT_W-1:0] core_out,
   output logic [BSR_OUT_W-1:0] pin_out,
   output logic [3:0]           tap_state
);
   localparam int N = BSR_IN_W + BSR_OUT_W;
   localparam logic [31:0] ID = {IDCODE_VAL[31:1], 1'b1};
   localparam logic [IR_W-1:0] OP_EXTEST = '0;
   localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(1);
   localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(2);
   localparam logic [IR_W-1:0] OP_INTEST = IR_W'(3);
   typedef enum logic [3:0] {
      EXIT2_DR = 4'h0, EXIT1_DR = 4'h1, SHIFT_DR = 4'h2, PAUSE_DR = 4'h3,
      SELECT_IR = 4'h4, UPDATE_DR = 4'h5, CAPTURE_DR = 4'h6, SELECT_DR = 4'h7,
      EXIT2_IR = 4'h8, EXIT1_IR = 4'h9, SHIFT_IR = 4'hA, PAUSE_IR = 4'hB,
      IDLE = 4'hC, UPDATE_IR = 4'hD, CAPTURE_IR = 4'hE, TLR = 4'hF
   } state_t;
   state_t state, nxt;
   logic [IR_W-1:0] ir, ir_sh;
   logic [N-1:0] bsr_sh, upd;
   logic [31:0] id_sh;
   logic byp, sel_bsr, sel_id, ir_col, dr_bit;
   assign sel_bsr = ir == OP_EXTEST || ir == OP_SAMPLE || ir == OP_INTEST;
   assign sel_id = ir == OP_IDCODE;
   assign ir_col = state inside {SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR};
   assign dr_bit = sel_bsr ? bsr_sh[0] : sel_id ? id_sh[0] : byp;
   assign pin_out = ir == OP_EXTEST ? upd[BSR_OUT_W-1:0] : core_out;
   assign core_in = ir == OP_INTEST ? upd[N-1:BSR_OUT_W] : pin_in;
   assign tap_state = state;
   always_ff @(posedge TCK or posedge TRST)
      if (TRST) state <= TLR;
      else state <= nxt;
   always_comb begin
      nxt = TLR;
      case (state)
         TLR:        nxt = TMS ? TLR : IDLE;
         IDLE:       nxt = TMS ? SELECT_DR : IDLE;
         SELECT_DR:  nxt = TMS ? SELECT_IR : CAPTURE_DR;
         CAPTURE_DR: nxt = TMS ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR:   nxt = TMS ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR:   nxt = TMS ? UPDATE_DR : PAUSE_DR;
         PAUSE_DR:   nxt = TMS ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR:   nxt = TMS ? UPDATE_DR : SHIFT_DR;
         UPDATE_DR:  nxt = TMS ? SELECT_DR : IDLE;
         SELECT_IR:  nxt = TMS ? TLR : CAPTURE_IR;
         CAPTURE_IR: nxt = TMS ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR:   nxt = TMS ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR:   nxt = TMS ? UPDATE_IR : PAUSE_IR;
         PAUSE_IR:   nxt = TMS ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR:   nxt = TMS ? UPDATE_IR : SHIFT_IR;
         UPDATE_IR:  nxt = TMS ? SELECT_DR : IDLE;
      endcase
   end
   always_ff @(posedge TCK or posedge TRST)
      if (TRST) begin
         ir <= OP_IDCODE;
         ir_sh <= '0;
         bsr_sh <= '0;
         upd <= '0;
         id_sh <= '0;
         byp <= 1'b0;
      end else begin
         // entering TLR also restores IDCODE so the instruction is valid on arrival
         if (state == TLR || nxt == TLR) ir <= OP_IDCODE;
         if (state == UPDATE_IR) ir <= ir_sh;
         if (state == CAPTURE_IR) ir_sh <= IR_W'(1);
         if (state == SHIFT_IR) ir_sh <= {TDI, ir_sh[IR_W-1:1]};
         if (state == CAPTURE_DR) begin
            if (sel_bsr) bsr_sh <= {pin_in, core_out};
            else if (sel_id) id_sh <= ID;
            else byp <= 1'b0;
         end
         if (state == SHIFT_DR) begin
            if (sel_bsr) bsr_sh <= {TDI, bsr_sh[N-1:1]};
            else if (sel_id) id_sh <= {TDI, id_sh[31:1]};
            else byp <= TDI;
         end
         if (state == UPDATE_DR && sel_bsr) upd <= bsr_sh;
      end
   // TDO follows bit 0 of the active path in every state; TDO_EN marks when it is meaningful
   always_ff @(negedge TCK or posedge TRST)
      if (TRST) begin
         TDO <= 1'b0;
         TDO_EN <= 1'b0;
      end else begin
         TDO <= ir_col ? ir_sh[0] : dr_bit;
         TDO_EN <= state == SHIFT_IR || state == SHIFT_DR;
      end
endmodule

// File: tb/tb_jtag_bscan_tap.sv
// tb_jtag_bscan_tap: directed self-checking bench for jtag_bscan_tap
module tb_jtag_bscan_tap;
   logic TCK = 1'b0, TRST = 1'b1, TMS = 1'b1, TDI = 1'b0;
   logic TDO, TDO_EN;
   logic [4:0] pin_in = 5'b10101, core_in;
   logic [3:0] core_out = 4'b0110, pin_out, tap_state;
   int n_assert = 0, n_fail = 0;
   localparam logic [31:0] ID_EXP = 32'h1234_5677;
   jtag_bscan_tap #(.IR_W(4), .BSR_IN_W(5), .BSR_OUT_W(4), .IDCODE_VAL(32'h1234_5676)) dut (
      .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
      .pin_in(pin_in), .core_in(core_in), .core_out(core_out), .pin_out(pin_out),
      .tap_state(tap_state)
   );
   always #5 TCK = ~TCK;
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end
   task automatic tick(input logic tms, input logic tdi);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      @(negedge TCK);
      #1;
   endtask
   task automatic load_ir(input logic [3:0] v, output logic [3:0] dout);
      tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
      for (int i = 0; i < 4; i++) begin
         dout[i] = TDO;
         tick(i == 3, v[i]);
      end
      tick(1, 0); tick(0, 0);
   endtask
   task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
      dout = '0;
      tick(1, 0); tick(0, 0); tick(0, 0);
      for (int i = 0; i < n; i++) begin
         dout[i] = TDO;
         tick(i == n - 1, din[i]);
      end
      tick(1, 0); tick(0, 0);
   endtask
   task automatic test_reset;
      repeat (2) @(negedge TCK);
      #1;
      n_assert++; if (tap_state !== 4'hF) begin n_fail++; $display("FAIL reset_state: got %h expected f", tap_state); end
      n_assert++; if (TDO !== 1'b0 || TDO_EN !== 1'b0) begin n_fail++; $display("FAIL reset_tdo: got tdo=%b en=%b expected 0 0", TDO, TDO_EN); end
      n_assert++; if (pin_out !== 4'b0110 || core_in !== 5'b10101) begin n_fail++; $display("FAIL reset_passthru: got pin_out=%b core_in=%b expected 0110 10101", pin_out, core_in); end
      TRST = 1'b0;
      tick(1, 0);
      n_assert++; if (tap_state !== 4'hF) begin n_fail++; $display("FAIL reset_hold_tlr: got %h expected f", tap_state); end
      tick(0, 0);
      n_assert++; if (tap_state !== 4'hC) begin n_fail++; $display("FAIL reset_to_idle: got %h expected c", tap_state); end
   endtask
   task automatic test_idcode;
      tick(1, 0);
      n_assert++; if (tap_state !== 4'h7) begin n_fail++; $display("FAIL id_select_dr: got %h expected 7", tap_state); end
      tick(0, 0);
      n_assert++; if (tap_state !== 4'h6) begin n_fail++; $display("FAIL id_capture_dr: got %h expected 6", tap_state); end
      tick(0, 0);
      n_assert++; if (tap_state !== 4'h2 || TDO_EN !== 1'b1) begin n_fail++; $display("FAIL id_shift_dr: got state=%h en=%b expected 2 1", tap_state, TDO_EN); end
      for (int i = 0; i < 32; i++) begin
         n_assert++; if (TDO !== ID_EXP[i]) begin n_fail++; $display("FAIL id_bit%0d: got %b expected %b", i, TDO, ID_EXP[i]); end
         tick(i == 31, 0);
      end
      tick(1, 0);
      n_assert++; if (tap_state !== 4'h5 || TDO_EN !== 1'b0) begin n_fail++; $display("FAIL id_update_dr: got state=%h en=%b expected 5 0", tap_state, TDO_EN); end
      tick(0, 0);
   endtask
   task automatic test_trst_midshift;
      logic [3:0] di;
      logic [63:0] d;
      load_ir(4'b0001, di);
      tick(1, 0); tick(0, 0); tick(0, 0);
      repeat (4) tick(0, 1);
      TRST = 1'b1;
      #1;
      n_assert++; if (tap_state !== 4'hF) begin n_fail++; $display("FAIL trst_state: got %h expected f", tap_state); end
      n_assert++; if (TDO !== 1'b0 || TDO_EN !== 1'b0) begin n_fail++; $display("FAIL trst_tdo: got tdo=%b en=%b expected 0 0", TDO, TDO_EN); end
      @(negedge TCK);
      #1;
      TRST = 1'b0;
      tick(0, 0);
      shift_dr(64'd0, 32, d);
      n_assert++; if (d[31:0] !== ID_EXP) begin n_fail++; $display("FAIL trst_ir_idcode: got %h expected %h", d[31:0], ID_EXP); end
      load_ir(4'b0000, di);
      n_assert++; if (pin_out !== 4'b0000) begin n_fail++; $display("FAIL trst_upd_out: got %b expected 0000", pin_out); end
      load_ir(4'b0011, di);
      n_assert++; if (core_in !== 5'b00000) begin n_fail++; $display("FAIL trst_upd_in: got %b expected 00000", core_in); end
   endtask
   task automatic test_sample_preload;
      logic [3:0] di;
      logic [63:0] d;
      load_ir(4'b0001, di);
      n_assert++; if (di !== 4'b0001) begin n_fail++; $display("FAIL ir_capture: got %b expected 0001", di); end
      shift_dr(64'b011101001, 9, d);
      n_assert++; if (d[8:0] !== 9'b101010110) begin n_fail++; $display("FAIL bsr_capture: got %b expected 101010110", d[8:0]); end
      n_assert++; if (pin_out !== 4'b0110 || core_in !== 5'b10101) begin n_fail++; $display("FAIL sample_passthru: got pin_out=%b core_in=%b expected 0110 10101", pin_out, core_in); end
   endtask
   task automatic test_extest;
      logic [3:0] di;
      load_ir(4'b0000, di);
      n_assert++; if (pin_out !== 4'b1001) begin n_fail++; $display("FAIL extest_pin_out: got %b expected 1001", pin_out); end
      n_assert++; if (core_in !== 5'b10101) begin n_fail++; $display("FAIL extest_core_in: got %b expected 10101", core_in); end
      core_out = 4'b0011;
      #1;
      n_assert++; if (pin_out !== 4'b1001) begin n_fail++; $display("FAIL extest_hold: got %b expected 1001", pin_out); end
   endtask
   task automatic test_intest;
      logic [3:0] di;
      load_ir(4'b0011, di);
      n_assert++; if (core_in !== 5'b01110) begin n_fail++; $display("FAIL intest_core_in: got %b expected 01110", core_in); end
      pin_in = 5'b00000;
      #1;
      n_assert++; if (core_in !== 5'b01110) begin n_fail++; $display("FAIL intest_hold: got %b expected 01110", core_in); end
      n_assert++; if (pin_out !== 4'b0011) begin n_fail++; $display("FAIL intest_pin_out: got %b expected 0011", pin_out); end
   endtask
   task automatic test_bypass;
      logic [3:0] di;
      logic [63:0] d;
      load_ir(4'b1111, di);
      shift_dr(64'b1101, 4, d);
      n_assert++; if (d[3:0] !== 4'b1010) begin n_fail++; $display("FAIL bypass_delay: got %b expected 1010", d[3:0]); end
      n_assert++; if (pin_out !== 4'b0011 || core_in !== 5'b00000) begin n_fail++; $display("FAIL bypass_passthru: got pin_out=%b core_in=%b expected 0011 00000", pin_out, core_in); end
      load_ir(4'b0101, di);
      shift_dr(64'b011, 3, d);
      n_assert++; if (d[2:0] !== 3'b110) begin n_fail++; $display("FAIL unknown_op_bypass: got %b expected 110", d[2:0]); end
   endtask
   task automatic test_pause;
      logic [3:0] di;
      load_ir(4'b0010, di);
      tick(1, 0); tick(0, 0); tick(0, 0);
      tick(0, 0); tick(0, 0); tick(1, 0);
      tick(0, 0);
      n_assert++; if (tap_state !== 4'h3 || TDO !== ID_EXP[3]) begin n_fail++; $display("FAIL pause_enter: got state=%h tdo=%b expected 3 %b", tap_state, TDO, ID_EXP[3]); end
      repeat (3) tick(0, 1);
      n_assert++; if (TDO !== ID_EXP[3]) begin n_fail++; $display("FAIL pause_hold: got %b expected %b", TDO, ID_EXP[3]); end
      tick(1, 0);
      n_assert++; if (tap_state !== 4'h0) begin n_fail++; $display("FAIL pause_exit2: got %h expected 0", tap_state); end
      tick(0, 0);
      n_assert++; if (tap_state !== 4'h2) begin n_fail++; $display("FAIL pause_reshift: got %h expected 2", tap_state); end
      for (int i = 3; i < 32; i++) begin
         n_assert++; if (TDO !== ID_EXP[i]) begin n_fail++; $display("FAIL pause_bit%0d: got %b expected %b", i, TDO, ID_EXP[i]); end
         tick(i == 31, 0);
      end
      tick(1, 0); tick(0, 0);
   endtask
   task automatic test_tlr_from_shift_ir;
      logic [63:0] d;
      tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
      n_assert++; if (tap_state !== 4'hA || TDO_EN !== 1'b1) begin n_fail++; $display("FAIL shift_ir: got state=%h en=%b expected a 1", tap_state, TDO_EN); end
      repeat (3) tick(0, 0);
      repeat (5) tick(1, 0);
      n_assert++; if (tap_state !== 4'hF) begin n_fail++; $display("FAIL tms5_tlr: got %h expected f", tap_state); end
      n_assert++; if (pin_out !== 4'b0011 || core_in !== 5'b00000) begin n_fail++; $display("FAIL tms5_ir_idcode: got pin_out=%b core_in=%b expected 0011 00000", pin_out, core_in); end
      tick(0, 0);
      shift_dr(64'd0, 32, d);
      n_assert++; if (d[31:0] !== ID_EXP) begin n_fail++; $display("FAIL tms5_idcode_dr: got %h expected %h", d[31:0], ID_EXP); end
   endtask
   initial begin
      test_reset;
      test_idcode;
      test_trst_midshift;
      test_sample_preload;
      test_extest;
      test_intest;
      test_bypass;
      test_pause;
      test_tlr_from_shift_ir;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/jtag_bscan_tap.md
JTAG_BSCAN_TAP -- requirements
Module: jtag_bscan_tap

Interface
REQ-001 Parameter IR_W, default 4: instruction register width, minimum 2.
REQ-002 Parameter BSR_IN_W, default 5: number of input boundary cells.
REQ-003 Parameter BSR_OUT_W, default 4: number of output boundary cells.
REQ-004 Parameter IDCODE_VAL, default 32'h1000_0001: device ID; bit 0 SHALL read as 1 regardless of the value given.
REQ-005 Port TCK, input, 1: the only clock; all state SHALL change on the rising edge unless stated otherwise.
REQ-006 Port TRST, input, 1: reset, asynchronous, active-high.
REQ-007 Port TMS, input, 1: TAP mode select, sampled on the TCK rising edge.
REQ-008 Port TDI, input, 1: serial data in, sampled on the TCK rising edge.
REQ-009 Port TDO, output, 1: serial data out, registered on the TCK falling edge.
REQ-010 Port TDO_EN, output, 1: high while in SHIFT_IR or SHIFT_DR, registered on the falling edge.
REQ-011 Port pin_in, input, BSR_IN_W: values at the device input pins.
REQ-012 Port core_in, output, BSR_IN_W: input values driven into the core logic.
REQ-013 Port core_out, input, BSR_OUT_W: output values produced by the core logic.
REQ-014 Port pin_out, output, BSR_OUT_W: values driven to the device output pins.
REQ-015 Port tap_state, output, 4: current TAP state encoding, for debug.

Function
REQ-016 The TAP SHALL implement the 16-state IEEE 1149.1 FSM with standard TMS transitions: TLR, IDLE, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, and the same seven states with IR in place of DR.
REQ-017 From any state, five consecutive TCK edges with TMS=1 SHALL reach TLR.
REQ-018 While in TLR, IR SHALL be set to IDCODE on every edge.
REQ-019 Opcodes SHALL be as follows:
- EXTEST = 0..000
- SAMPLE_PRELOAD = 0..001
- IDCODE = 0..010
- INTEST = 0..011
- BYPASS = all ones
- any other code SHALL select BYPASS.
REQ-020 Shifting SHALL be LSB-first: TDI enters the MSB, the register shifts right, and bit 0 drives TDO.
REQ-021 CAPTURE_IR SHALL load the IR shift stage with 0..01.
REQ-022 UPDATE_IR SHALL copy the IR shift stage into the active IR.
REQ-023 The BSR SHALL have N = BSR_IN_W + BSR_OUT_W bits, ordered {input cells [N-1:BSR_OUT_W], output cells [BSR_OUT_W-1:0]}.
REQ-024 When IR selects the BSR (EXTEST, SAMPLE_PRELOAD, INTEST), CAPTURE_DR SHALL load the BSR shift stage with {pin_in, core_out}.
REQ-025 When IR selects the BSR, UPDATE_DR SHALL copy the BSR shift stage into the BSR update register (upd).
REQ-026 The selected data register SHALL be:
- BSR for EXTEST, SAMPLE_PRELOAD and INTEST
- a 32-bit ID register for IDCODE, which CAPTURE_DR loads with IDCODE_VAL
- a 1-bit bypass register for BYPASS, which CAPTURE_DR loads with 0.
REQ-027 pin_out SHALL be upd[BSR_OUT_W-1:0] under EXTEST, otherwise core_out, combinationally.
REQ-028 core_in SHALL be upd[N-1:BSR_OUT_W] under INTEST, otherwise pin_in, combinationally.
REQ-029 SAMPLE_PRELOAD SHALL NOT alter pin_out or core_in.
REQ-030 PAUSE states SHALL hold all shift contents unchanged.
REQ-031 Shift-through latency SHALL be:
- a bit presented on TDI reaches TDO after L shift edges (L = 1 for BYPASS, 32 for IDCODE, N for BSR, IR_W for IR)
- TDO SHALL be valid on the falling edge following the last of those shift edges.
REQ-032 An IR change at UPDATE_IR SHALL take effect on pin_out and core_in in the same cycle it updates.

Reset
REQ-033 TRST=1 SHALL immediately force:
- state TLR
- IR = IDCODE
- upd = 0
- all shift stages = 0
- TDO = 0
- TDO_EN = 0.
REQ-034 TRST asserted mid-shift SHALL discard any partial shift; no update SHALL occur.
REQ-035 After TRST is released, the first rising edge SHALL evaluate TMS from TLR.

Verification
REQ-036 Reset then IDLE -> SELECT_DR -> CAPTURE_DR -> SHIFT_DR, then 32 shifts -> TDO sequence equals IDCODE_VAL LSB-first, starting with 1.
REQ-037 Defaults; load IR 0001 (TDI 1,0,0,0); shift DR with TDI 1,0,0,1,0,1,1,1,0; UPDATE_DR -> upd = 9'b011101001, pin_out == core_out.
REQ-038 Preload as in REQ-037, then load IR 0000 (EXTEST) -> pin_out = 4'b1001 after UPDATE_IR.
REQ-039 Load IR 1111; shift DR with TDI pattern 1,0,1,1 -> TDO pattern 0,1,0,1 (one-bit delay).
REQ-040 Load IR 0011 with upd input cells 5'b01110 -> core_in = 5'b01110 independent of pin_in.
REQ-041 Pulse TRST during SHIFT_DR after 4 bits -> state TLR, upd unchanged at 0, IR = IDCODE.
REQ-042 From SHIFT_IR, five TMS=1 edges -> TLR and IR = IDCODE.
